challenge_response_prover: RTL and testbench

Prover (responder) end of the 4-bit challenge/response authentication link. It accepts a challenge over a valid/ready handshake and computes the keyed response over a fixed number of cycles. It then presents the response over a second valid/ready handshake to whatever carries it to the authenticator. It also flags replayed challenges and keeps a saturating count of answered challenges.

---
 rtl/cr_pkg.sv | 22 ++
 rtl/challenge_response_prover.sv | 104 ++++++++++
 tb/tb_challenge_response_prover.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cr_pkg.sv
// Shared definitions for both ends of the 4-bit challenge/response link.
// The authenticator imports the same key and response function, so both sides agree.
package cr_pkg;

  localparam int                     CR_WIDTH = 4;
  localparam logic [CR_WIDTH-1:0]    CR_KEY   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESPOND
  } cr_state_e;

  // Pure bitwise XOR with no carry between bits.
  function automatic logic [CR_WIDTH-1:0] cr_response(
    input logic [CR_WIDTH-1:0] challenge,
    input logic [CR_WIDTH-1:0] key
  );
    return challenge ^ key;
  endfunction

endpackage

// File: rtl/challenge_response_prover.sv
// Prover end of the challenge/response link: accepts a challenge, computes the keyed
// response over LATENCY cycles, presents it, flags replays, counts answered challenges.
module challenge_response_prover
  import cr_pkg::*;
#(
  parameter int               WIDTH   = CR_WIDTH,
  parameter logic [WIDTH-1:0] KEY     = WIDTH'(CR_KEY),
  parameter int               LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chal_valid,
  output logic             chal_ready,
  input  logic [WIDTH-1:0] challenge,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] response,
  output logic             replay,
  output logic [7:0]       resp_count
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  cr_state_e        state_q, state_d;
  // The latched challenge doubles as the replay history: both are updated on every accept.
  logic [WIDTH-1:0] chal_q, chal_d;
  logic             last_valid_q, last_valid_d;
  logic             pend_replay_q, pend_replay_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic             replay_q, replay_d;
  logic [7:0]       count_q, count_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through the case leaves one unassigned and infers a latch.
    state_d       = state_q;
    chal_d        = chal_q;
    last_valid_d  = last_valid_q;
    pend_replay_d = pend_replay_q;
    cnt_d         = cnt_q;
    resp_d        = resp_q;
    replay_d      = replay_q;
    count_d       = count_q;

    unique case (state_q)
      IDLE: begin
        if (chal_valid) begin
          chal_d        = challenge;
          pend_replay_d = last_valid_q && (challenge == chal_q);
          last_valid_d  = 1'b1;
          cnt_d         = CNT_LOAD;
          state_d       = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_d   = pend_replay_q ? '0 : (chal_q ^ KEY);
          replay_d = pend_replay_q;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        if (resp_ready) begin
          state_d = IDLE;
          if (!replay_q && count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q       <= IDLE;
      chal_q        <= '0;
      last_valid_q  <= 1'b0;
      pend_replay_q <= 1'b0;
      cnt_q         <= 4'd0;
      resp_q        <= '0;
      replay_q      <= 1'b0;
      count_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      chal_q        <= chal_d;
      last_valid_q  <= last_valid_d;
      pend_replay_q <= pend_replay_d;
      cnt_q         <= cnt_d;
      resp_q        <= resp_d;
      replay_q      <= replay_d;
      count_q       <= count_d;
    end
  end

  // Gated by reset so no challenge appears accepted while the block is held in reset.
  assign chal_ready = (state_q == IDLE) && reset;
  assign resp_valid = (state_q == RESPOND);
  assign response   = resp_q;
  assign replay     = replay_q;
  assign resp_count = count_q;

endmodule

// File: tb/tb_challenge_response_prover.sv
// Directed bench for challenge_response_prover: vector table plus hand-written
// backpressure, mid-operation reset and count saturation sequences.
module tb_challenge_response_prover;

  localparam int         LAT     = 2;
  localparam logic [3:0] TB_KEY  = 4'b1100;

  logic       clk = 1'b0;
  logic       reset;
  logic       chal_valid;
  logic       chal_ready;
  logic [3:0] challenge;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] response;
  logic       replay;
  logic [7:0] resp_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] chal;
    logic [3:0] exp_resp;
    logic       exp_rep;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  challenge_response_prover #(
    .WIDTH  (4),
    .KEY    (4'b1100),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chal_valid(chal_valid),
    .chal_ready(chal_ready),
    .challenge (challenge),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .response  (response),
    .replay    (replay),
    .resp_count(resp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic accept(input logic [3:0] c);
    int waited = 0;
    chal_valid = 1'b1;
    challenge  = c;
    while (!chal_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", chal_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chal_valid = 1'b0;
  endtask

  task automatic expect_resp(input logic [3:0] er, input logic erep);
    int lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LAT);
    check("response", response, er);
    check("replay", replay, erep);
    check("chal_ready_busy", chal_ready, 1'b0);
  endtask

  task automatic handshake(input logic [7:0] ecount);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid", resp_valid, 1'b0);
    check("post_hs_ready", chal_ready, 1'b1);
    check("resp_count", resp_count, ecount);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] c;
    logic [7:0] exp_cnt;

    vecs[0] = '{4'b1010, 4'b0110, 1'b0, 8'd1};
    vecs[1] = '{4'b1110, 4'b0010, 1'b0, 8'd2};
    vecs[2] = '{4'b1100, 4'b0000, 1'b0, 8'd3};
    vecs[3] = '{4'b1010, 4'b0110, 1'b0, 8'd4};
    vecs[4] = '{4'b1010, 4'b0000, 1'b1, 8'd4};
    vecs[5] = '{4'b0011, 4'b1111, 1'b0, 8'd5};
    vecs[6] = '{4'b1010, 4'b0110, 1'b0, 8'd6};
    vecs[7] = '{4'b0000, 4'b1100, 1'b0, 8'd7};
    vecs[8] = '{4'b1111, 4'b0011, 1'b0, 8'd8};

    reset      = 1'b0;
    chal_valid = 1'b0;
    challenge  = 4'b0000;
    resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_chal_ready", chal_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_response", response, 4'b0000);
    check("rst_replay", replay, 1'b0);
    check("rst_count", resp_count, 8'd0);
    reset = 1'b1;
    #1;
    check("rel_chal_ready", chal_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      accept(vecs[i].chal);
      expect_resp(vecs[i].exp_resp, vecs[i].exp_rep);
      handshake(vecs[i].exp_cnt);
    end

    // Backpressure: a new challenge waits while the response is held.
    resp_ready = 1'b0;
    accept(4'b0101);
    expect_resp(4'b1001, 1'b0);
    chal_valid = 1'b1;
    challenge  = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", resp_valid, 1'b1);
      check("bp_response", response, 4'b1001);
      check("bp_chal_ready", chal_ready, 1'b0);
    end
    handshake(8'd9);
    @(posedge clk);
    @(negedge clk);
    chal_valid = 1'b0;
    check("bp_accepted", chal_ready, 1'b0);
    expect_resp(4'b1010, 1'b0);
    handshake(8'd10);

    // Reset during COMPUTE drops the pending response and clears replay history.
    accept(4'b0110);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", resp_valid, 1'b0);
    check("mid_rst_response", response, 4'b0000);
    check("mid_rst_count", resp_count, 8'd0);
    check("mid_rst_ready", chal_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rel_ready", chal_ready, 1'b1);
    @(negedge clk);
    check("mid_idle_valid", resp_valid, 1'b0);
    accept(4'b0110);
    expect_resp(4'b1010, 1'b0);
    handshake(8'd1);

    // Saturation of the answered-challenge count.
    exp_cnt = 8'd1;
    c       = 4'b0001;
    for (int i = 0; i < 260; i++) begin
      c = (i % 2 == 1) ? 4'b0010 : 4'b0001;
      accept(c);
      expect_resp(c ^ TB_KEY, 1'b0);
      exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
      handshake(exp_cnt);
    end
    accept(c);
    expect_resp(4'b0000, 1'b1);
    handshake(8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
